temp_poll_ctrl: RTL

Measurement scheduler for the 1-Wire temperature front end `temp_1wire`. The block starts a conversion by pulsing the sensor module's reset input. It waits for `done` and latches `T_data`. It applies a watchdog timeout, tracks a hysteresis over-temperature alarm, and repeats at a programmable interval. It sits between `temp_1wire` and the housekeeping/register logic, so the rest of the design sees only a validated temperature word plus status.

---
 rtl/temp_poll_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/temp_poll_ctrl.sv
// temp_poll_ctrl
// Measurement scheduler for the temp_1wire front end. It starts a conversion,
// waits for the done edge under a watchdog, latches the sample, keeps a
// hysteresis over-temperature alarm and repeats at a programmable interval.
module temp_poll_ctrl #(
    parameter int unsigned START_CYC   = 13,
    parameter int unsigned TIMEOUT_CYC = 125_000_000,
    parameter int unsigned PERIOD_CYC  = 125_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        trig,
    input  logic [15:0] thr_hi,
    input  logic [15:0] thr_lo,
    output logic        sens_start,
    input  logic        sens_done,
    input  logic [15:0] sens_data,
    output logic [15:0] temp_out,
    output logic        temp_valid,
    output logic        alarm,
    output logic        err_timeout,
    output logic [7:0]  err_cnt,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    // Terminal counts; the counters run 0..N-1
    localparam logic [31:0] START_LAST   = 32'(START_CYC - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] PERIOD_LAST  = 32'(PERIOD_CYC - 1);

    // Saturating increment for the timeout counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'd255) begin
            return 8'd255;
        end else begin
            return v + 8'd1;
        end
    endfunction

    state_t      state_r;
    logic [31:0] cnt_r;
    logic [31:0] wd_r;
    logic        done_d_r;
    logic        en_d_r;
    logic        done_rise_s;
    logic        en_fall_s;

    // Only a fresh rising edge of done counts; a level already high is ignored
    assign done_rise_s = sens_done & ~done_d_r;
    assign en_fall_s   = en_d_r & ~en;

    // Scheduler FSM with all outputs registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 32'd0;
            wd_r        <= 32'd0;
            done_d_r    <= 1'b0;
            en_d_r      <= 1'b0;
            sens_start  <= 1'b0;
            temp_out    <= 16'd0;
            temp_valid  <= 1'b0;
            alarm       <= 1'b0;
            err_timeout <= 1'b0;
            err_cnt     <= 8'd0;
            busy        <= 1'b0;
        end else begin
            done_d_r    <= sens_done;
            en_d_r      <= en;
            temp_valid  <= 1'b0;
            err_timeout <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (trig || en) begin
                        state_r    <= ST_START;
                        cnt_r      <= 32'd0;
                        wd_r       <= 32'd0;
                        sens_start <= 1'b1;
                        busy       <= 1'b1;
                    end else begin
                        sens_start <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                ST_START: begin
                    if (cnt_r == START_LAST) begin
                        state_r    <= ST_WAIT;
                        sens_start <= 1'b0;
                        wd_r       <= 32'd0;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                ST_WAIT: begin
                    // The done edge takes priority over a coincident expiry
                    if (done_rise_s) begin
                        state_r <= ST_CAPTURE;
                    end else if (wd_r == TIMEOUT_LAST) begin
                        state_r     <= ST_GAP;
                        cnt_r       <= 32'd0;
                        busy        <= 1'b0;
                        err_timeout <= 1'b1;
                        err_cnt     <= sat_inc8(err_cnt);
                    end else begin
                        wd_r <= wd_r + 32'd1;
                    end
                end
                ST_CAPTURE: begin
                    temp_out   <= sens_data;
                    temp_valid <= 1'b1;
                    if ($signed(sens_data) >= $signed(thr_hi)) begin
                        alarm <= 1'b1;
                    end else if ($signed(sens_data) < $signed(thr_lo)) begin
                        alarm <= 1'b0;
                    end else begin
                        alarm <= alarm;
                    end
                    state_r <= ST_GAP;
                    cnt_r   <= 32'd0;
                    busy    <= 1'b0;
                end
                ST_GAP: begin
                    if (trig) begin
                        state_r    <= ST_START;
                        cnt_r      <= 32'd0;
                        wd_r       <= 32'd0;
                        sens_start <= 1'b1;
                        busy       <= 1'b1;
                    end else if (en_fall_s) begin
                        state_r <= ST_IDLE;
                    end else if (cnt_r == PERIOD_LAST) begin
                        if (en) begin
                            state_r    <= ST_START;
                            cnt_r      <= 32'd0;
                            wd_r       <= 32'd0;
                            sens_start <= 1'b1;
                            busy       <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    sens_start <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
